lane_sprite_mover: RTL

//  Parametrised lane-based sprite engine for the 160x120 VGA car game. Owns the player

---
 rtl/lane_sprite_mover.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lane_sprite_mover.sv
// Lane-based player sprite engine: latches left/right requests and, on a game tick,
// erases the sprite in its old lane and redraws it from the sprite ROM in the new lane.
module lane_sprite_mover #(
    parameter int            XW_BITS    = 3,
    parameter int            YH_BITS    = 3,
    parameter int            NUM_LANES  = 3,
    parameter int            START_LANE = 1,
    parameter int            LANE_X0    = 40,
    parameter int            LANE_PITCH = 35,
    parameter int            LANE_Y     = 70,
    parameter int            CW         = 3,
    parameter logic [CW-1:0] BG_COLOUR  = 3'b000,
    parameter logic [CW-1:0] TRANSP     = 3'b101
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic                       tick,
    input  logic                       left_req,
    input  logic                       right_req,
    output logic [XW_BITS+YH_BITS-1:0] rom_addr,
    input  logic [CW-1:0]              rom_data,
    output logic [7:0]                 oX,
    output logic [6:0]                 oY,
    output logic [CW-1:0]              oColour,
    output logic                       oPlot,
    output logic [2:0]                 lane,
    output logic                       busy,
    output logic [1:0]                 fsm_state
);

    localparam int AW = XW_BITS + YH_BITS;

    localparam logic [1:0] DRAW_INIT = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] ERASE     = 2'd2;
    localparam logic [1:0] DRAW      = 2'd3;

    logic [1:0]         state;
    logic [AW:0]        cnt;          // top bit set marks the flush cycle
    logic [2:0]         next_lane;
    logic               pend_l;
    logic               pend_r;
    logic               p_valid;
    logic               p_draw;
    logic [7:0]         p_x;
    logic [6:0]         p_y;

    logic [XW_BITS-1:0] xc;
    logic [YH_BITS-1:0] yc;
    logic [7:0]         base_x;
    logic               scanning;
    logic               flush;
    logic               take;
    logic               target_ok;
    logic [2:0]         target;

    assign xc        = cnt[XW_BITS-1:0];
    assign yc        = cnt[AW-1:XW_BITS];
    assign rom_addr  = cnt[AW-1:0];
    assign base_x    = 8'(LANE_X0 + int'(lane) * LANE_PITCH);
    assign scanning  = (state != IDLE);
    assign flush     = cnt[AW];
    assign take      = (state == IDLE) && tick && (pend_l || pend_r);
    assign target    = pend_l ? (lane - 3'd1) : (lane + 3'd1);
    assign target_ok = pend_l ? (lane != 3'd0) : (lane != 3'(NUM_LANES - 1));

    // ROM data lines up with the registered pixel stage, so colour/transparency are resolved here.
    assign oX        = p_x;
    assign oY        = p_y;
    assign oColour   = p_valid ? (p_draw ? rom_data : BG_COLOUR) : '0;
    assign oPlot     = p_valid && !(p_draw && (rom_data == TRANSP));
    assign busy      = scanning;
    assign fsm_state = state;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= DRAW_INIT;
            cnt       <= '0;
            lane      <= 3'(START_LANE);
            next_lane <= 3'(START_LANE);
            pend_l    <= 1'b0;
            pend_r    <= 1'b0;
            p_valid   <= 1'b0;
            p_draw    <= 1'b0;
            p_x       <= '0;
            p_y       <= '0;
        end else begin
            p_valid <= scanning && !flush;
            p_draw  <= (state == DRAW) || (state == DRAW_INIT);
            if (scanning) begin
                p_x <= base_x + 8'(xc);
                p_y <= 7'(LANE_Y) + 7'(yc);
                cnt <= flush ? '0 : cnt + 1'b1;
            end

            case (state)
                DRAW_INIT: if (flush) state <= IDLE;
                IDLE: begin
                    if (take && target_ok) begin
                        next_lane <= target;
                        state     <= ERASE;
                    end
                end
                ERASE: begin
                    if (flush) begin
                        lane  <= next_lane;
                        state <= DRAW;
                    end
                end
                default: if (flush) state <= IDLE;
            endcase

            // A fresh request in the same cycle as consumption wins over the clear.
            if (left_req && right_req) begin
                pend_l <= 1'b0;
                pend_r <= 1'b0;
            end else if (left_req) begin
                pend_l <= 1'b1;
                pend_r <= 1'b0;
            end else if (right_req) begin
                pend_l <= 1'b0;
                pend_r <= 1'b1;
            end else if (take) begin
                pend_l <= 1'b0;
                pend_r <= 1'b0;
            end
        end
    end

endmodule
